// File: rtl/reg_file_32x32_if.sv
// reg_file_32x32_if: write port and two read ports of the KGP-RISC register file
interface reg_file_32x32_if;
  logic        RegWrite;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [4:0]  rdAddrA;
  logic [31:0] rdDataA;
  logic [4:0]  rdAddrB;
  logic [31:0] rdDataB;
  modport master (
    output RegWrite, wrAddr, wrData, rdAddrA, rdAddrB,
    input  rdDataA, rdDataB
  );
  modport slave (
    input  RegWrite, wrAddr, wrData, rdAddrA, rdAddrB,
    output rdDataA, rdDataB
  );
endinterface

// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 32x32 register file, two combinational read ports, one clocked write port
module reg_file_32x32 (
  input logic           clk,
  input logic           reset,
  reg_file_32x32_if.slave bus
);
  logic [31:0] regs [32];
  // clear everything asynchronously on reset, otherwise store wrData on enabled edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.RegWrite) begin
      regs[bus.wrAddr] <= bus.wrData;
    end
  end
  // reads have no bypass; gating on reset keeps outputs at zero while reset is held
  always_comb begin
    bus.rdDataA = reset ? regs[bus.rdAddrA] : '0;
    bus.rdDataB = reset ? regs[bus.rdAddrB] : '0;
  end
endmodule

// File: tb/tb_reg_file_32x32.sv
// tb_reg_file_32x32: directed scoreboard bench for reg_file_32x32
module tb_reg_file_32x32;
  logic clk = 0;
  logic reset = 1;
  reg_file_32x32_if bus ();
  reg_file_32x32 dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] expA;
    logic [31:0] expB;
  } exp_t;

  exp_t q[$];
  event sampleEv;
  int checks = 0;
  int errors = 0;

  // monitor: whenever stimulus signals that outputs have settled, pop and compare
  initial begin
    exp_t e;
    forever begin
      @(sampleEv);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.rdDataA !== e.expA) begin
          errors++;
          $display("FAIL %s portA got %h want %h", e.name, bus.rdDataA, e.expA);
        end
        checks++;
        if (bus.rdDataB !== e.expB) begin
          errors++;
          $display("FAIL %s portB got %h want %h", e.name, bus.rdDataB, e.expB);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [4:0] a, input logic [4:0] b,
                     input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    bus.rdAddrA = a;
    bus.rdAddrB = b;
    #1;
    e.name = n;
    e.expA = ea;
    e.expB = eb;
    q.push_back(e);
    ->sampleEv;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.RegWrite = 1;
    bus.wrAddr = a;
    bus.wrData = d;
    @(posedge clk);
    #1 bus.RegWrite = 0;
  endtask

  initial begin
    bus.RegWrite = 0;
    bus.wrAddr = 0;
    bus.wrData = 0;
    bus.rdAddrA = 0;
    bus.rdAddrB = 0;
    #1 reset = 0;
    chk("reset_clear", 5'd0, 5'd31, 32'h0, 32'h0);
    // write attempted while reset is held must be dropped
    @(negedge clk);
    bus.RegWrite = 1;
    bus.wrAddr = 5'd3;
    bus.wrData = 32'h5;
    @(posedge clk);
    #1 bus.RegWrite = 0;
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 32; i++)
      chk($sformatf("reset_sweep_%0d", i), 5'(i), 5'(31 - i), 32'h0, 32'h0);

    wr(5'd10, 32'h15);
    wr(5'd15, 32'h3);
    chk("basic_rw", 5'd15, 5'd10, 32'h3, 32'h15);

    @(negedge clk);
    bus.wrAddr = 5'd10;
    bus.wrData = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1 chk("write_disable", 5'd10, 5'd15, 32'h15, 32'h3);

    @(negedge clk);
    bus.RegWrite = 1;
    bus.wrAddr = 5'd5;
    bus.wrData = 32'hDEAD_BEEF;
    chk("rdw_before", 5'd5, 5'd5, 32'h0, 32'h0);
    @(posedge clk);
    #1 bus.RegWrite = 0;
    chk("rdw_after", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    wr(5'd0, 32'h1);
    wr(5'd31, 32'h8000_0000);
    chk("pre_reset", 5'd0, 5'd31, 32'h1, 32'h8000_0000);
    @(negedge clk);
    #1 reset = 0;
    chk("async_reset", 5'd0, 5'd31, 32'h0, 32'h0);
    bus.RegWrite = 1;
    bus.wrAddr = 5'd0;
    bus.wrData = 32'hAA;
    @(posedge clk);
    #1 bus.RegWrite = 0;
    @(negedge clk);
    reset = 1;
    chk("reset_write_dropped", 5'd0, 5'd10, 32'h0, 32'h0);
    chk("reset_rdw_lost", 5'd5, 5'd3, 32'h0, 32'h0);

    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 32; i++)
      chk($sformatf("full_sweep_%0d", i), 5'(i), 5'((i + 16) % 32),
          32'(i) * 32'h0101_0101, 32'((i + 16) % 32) * 32'h0101_0101);
    chk("sweep_edge_hi", 5'd31, 5'd0, 32'h1F1F_1F1F, 32'h0);

    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
